// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters.
// One outstanding transaction at a time; a watchdog turns a stalled access into an error response.
module mem_port_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_read,
   input  logic [NUM_REQ-1:0]               req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [NUM_REQ-1:0]               rsp_error,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             memory_read_request,
   output logic                             memory_write_request,
   output logic [ADDR_WIDTH-1:0]            memory_addr,
   output logic [DATA_WIDTH-1:0]            memory_write_data,
   input  logic                             memory_response,
   input  logic [DATA_WIDTH-1:0]            memory_read_data,
   output logic                             busy,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          ptr_q, ptr_d, gid_q, gid_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
   logic                   rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;
   logic [NUM_REQ-1:0]     valid_q, valid_d, err_q, err_d;
   logic [CW-1:0]          cnt_q, cnt_d;

   logic [NUM_REQ-1:0]     active;
   logic                   found, timeout;
   logic [GW-1:0]          win;
   int                     idx;

   assign active  = req_read | req_write;
   // cnt_q counts completed WAIT cycles, so the abort lands at the end of the TIMEOUT_CYCLES-th one
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && active[idx]) begin
            found = 1'b1;
            win   = GW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      valid_d = '0;
      err_d   = '0;
      rdata_d = '0;
      case (state_q)
         IDLE: if (found) begin
            state_d = WAIT;
            ptr_d   = win;
            gid_d   = win;
            addr_d  = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            wr_d    = req_write[win];
            rd_d    = !req_write[win];
            cnt_d   = '0;
         end
         WAIT: begin
            if (memory_response || timeout) begin
               state_d = RESP;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               for (int i = 0; i < NUM_REQ; i++) begin
                  valid_d[i] = (gid_q == GW'(i));
                  err_d[i]   = (gid_q == GW'(i)) && !memory_response;
               end
               if (memory_response && rd_q) rdata_d = memory_read_data;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= GW'(NUM_REQ - 1);
         gid_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= '0;
         err_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsp_valid            = valid_q;
   assign rsp_error            = err_q;
   assign rsp_rdata            = rdata_q;
   assign memory_read_request  = rd_q;
   assign memory_write_request = wr_q;
   assign memory_addr          = addr_q;
   assign memory_write_data    = wdata_q;
   assign busy                 = busy_q;
   assign grant_id             = gid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int N = 3, AW = 32, DW = 32, TO = 4, GW = $clog2(N);

   logic clk = 1'b0, reset = 1'b1;
   logic [N-1:0] req_read = '0, req_write = '0;
   logic [AW-1:0] addr_a [N];
   logic [DW-1:0] wd_a [N];
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0] rsp_valid, rsp_error;
   logic [DW-1:0] rsp_rdata, memory_write_data, memory_read_data;
   logic [AW-1:0] memory_addr;
   logic memory_read_request, memory_write_request, memory_response, busy;
   logic [GW-1:0] grant_id;

   logic auto_resp = 1'b0, man_resp = 1'b0, mem_auto = 1'b0;
   logic [DW-1:0] auto_rdata = '0, man_rdata = '0;
   int mem_fix = -1, mem_dly = -1;
   bit mem_sched = 0, chk_en = 0;
   int n_chk = 0, n_fail = 0;

   assign memory_response  = auto_resp | man_resp;
   assign memory_read_data = mem_auto ? auto_rdata : man_rdata;

   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = addr_a[i];
         req_wdata[i*DW +: DW] = wd_a[i];
      end
   end

   always #5 clk = ~clk;

   mem_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
      .rsp_rdata(rsp_rdata), .memory_read_request(memory_read_request),
      .memory_write_request(memory_write_request), .memory_addr(memory_addr),
      .memory_write_data(memory_write_data), .memory_response(memory_response),
      .memory_read_data(memory_read_data), .busy(busy), .grant_id(grant_id));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level reference: who owns the port, how long it has waited, and what it returns.
   logic [N-1:0] e_valid = '0, e_err = '0;
   logic [DW-1:0] e_rdata = '0, e_wdata = '0;
   logic [AW-1:0] e_addr = '0;
   logic e_rd = 0, e_wr = 0, e_busy = 0;
   logic [GW-1:0] e_gid = '0;
   int m_last = N - 1, m_owner = -1, m_waited = 0, m_c = 0;
   bit m_resp = 0, m_is_wr = 0;

   always @(posedge clk) begin
      if (reset) begin
         e_valid = '0; e_err = '0; e_rdata = '0; e_wdata = '0; e_addr = '0;
         e_rd = 0; e_wr = 0; e_busy = 0; e_gid = '0;
         m_last = N - 1; m_owner = -1; m_resp = 0;
      end else if (m_resp) begin
         m_resp = 0; e_valid = '0; e_err = '0; e_rdata = '0; e_busy = 0;
      end else if (m_owner >= 0) begin
         m_waited++;
         if (memory_response || m_waited == TO) begin
            e_valid = '0; e_err = '0;
            e_valid[m_owner] = 1'b1;
            e_err[m_owner]   = !memory_response;
            e_rdata = (memory_response && !m_is_wr) ? memory_read_data : '0;
            e_rd = 0; e_wr = 0; m_resp = 1; m_owner = -1;
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            m_c = (m_last + k) % N;
            if (m_owner < 0 && (req_read[m_c] || req_write[m_c])) m_owner = m_c;
         end
         if (m_owner >= 0) begin
            m_last = m_owner; e_gid = GW'(m_owner);
            m_is_wr = req_write[m_owner];
            e_wr = m_is_wr; e_rd = !m_is_wr;
            e_addr = addr_a[m_owner]; e_wdata = wd_a[m_owner];
            m_waited = 0; e_busy = 1;
         end
      end
   end

   always @(negedge clk) if (chk_en) begin
      chk("rd_req",    64'(memory_read_request),  64'(e_rd));
      chk("wr_req",    64'(memory_write_request), 64'(e_wr));
      chk("mem_addr",  64'(memory_addr),          64'(e_addr));
      chk("mem_wdata", 64'(memory_write_data),    64'(e_wdata));
      chk("rsp_valid", 64'(rsp_valid),            64'(e_valid));
      chk("rsp_error", 64'(rsp_error),            64'(e_err));
      chk("rsp_rdata", 64'(rsp_rdata),            64'(e_rdata));
      chk("busy",      64'(busy),                 64'(e_busy));
      chk("grant_id",  64'(grant_id),             64'(e_gid));
   end

   // Auto memory: answers each strobe after 0..6 cycles, sometimes sends stray pulses while idle.
   always @(negedge clk) begin
      auto_resp  = 1'b0;
      auto_rdata = $urandom | 32'h1;
      if (mem_auto) begin
         if (memory_read_request || memory_write_request) begin
            if (!mem_sched) begin
               mem_sched = 1;
               mem_dly = (mem_fix >= 0) ? mem_fix : int'($urandom_range(0, 6));
            end
            if (mem_dly == 0) begin
               auto_resp = 1'b1;
               mem_dly = -1;
            end else if (mem_dly > 0) mem_dly--;
         end else begin
            mem_sched = 0;
            if ($urandom % 16 == 0) auto_resp = 1'b1;
         end
      end
   end

   task automatic wait_strobe(input string nm);
      int n = 0;
      while (!(memory_read_request || memory_write_request) && n < 40) begin @(negedge clk); n++; end
      chk(nm, 64'(memory_read_request || memory_write_request), 64'd1);
   endtask

   task automatic wait_rsp(input string nm);
      int n = 0;
      while (rsp_valid == '0 && n < 40) begin @(negedge clk); n++; end
      chk(nm, 64'(rsp_valid != '0), 64'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin @(negedge clk); n++; end
      chk("drain_idle", 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req_read = '0; req_write = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rand_step();
      int t;
      for (int i = 0; i < N; i++) begin
         if (rsp_valid[i]) begin
            req_read[i] = 0; req_write[i] = 0;
         end else if (!(req_read[i] || req_write[i])) begin
            if ($urandom % 4 == 0) begin
               t = int'($urandom % 3);
               req_read[i] = (t != 1); req_write[i] = (t != 0);
               addr_a[i] = $urandom; wd_a[i] = $urandom;
            end
         end else if (!(busy && grant_id == GW'(i)) && $urandom % 50 == 0) begin
            req_read[i] = 0; req_write[i] = 0;
         end
      end
      reset = ($urandom % 600 == 0);
   endtask

   initial begin
      int g [$];
      int n;
      bit prev;
      for (int i = 0; i < N; i++) begin addr_a[i] = '0; wd_a[i] = '0; end
      @(negedge clk);
      chk_en = 1;
      do_reset();
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_strobes", 64'({memory_read_request, memory_write_request}), 64'd0);
      chk("reset_addr", 64'(memory_addr), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);

      // single read
      req_read[0] = 1; addr_a[0] = 32'h100;
      wait_strobe("t1_strobe");
      chk("t1_rd", 64'(memory_read_request), 64'd1);
      chk("t1_addr", 64'(memory_addr), 64'h100);
      @(negedge clk); @(negedge clk);
      man_resp = 1; man_rdata = 32'hDEADBEEF;
      @(negedge clk);
      man_resp = 0;
      chk("t1_rsp_valid", 64'(rsp_valid), 64'b001);
      chk("t1_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
      chk("t1_err", 64'(rsp_error), 64'd0);
      chk("t1_strobe_low", 64'(memory_read_request), 64'd0);
      req_read = '0;
      wait_idle();

      // contention, all three held
      mem_auto = 1; mem_fix = 1;
      do_reset();
      for (int i = 0; i < N; i++) addr_a[i] = 32'h1000 * (i + 1);
      req_read = 3'b111;
      prev = 0; n = 0;
      while (g.size() < 6 && n < 300) begin
         @(negedge clk); n++;
         if ((memory_read_request || memory_write_request) && !prev) g.push_back(int'(grant_id));
         prev = memory_read_request || memory_write_request;
      end
      chk("t2_grants", 64'(g.size()), 64'd6);
      for (int k = 0; k < g.size(); k++) chk("t2_order", 64'(g[k]), 64'(k % 3));
      req_read = '0;
      wait_idle();

      // write on requester 1
      mem_fix = 2;
      do_reset();
      req_write[1] = 1; addr_a[1] = 32'h2000; wd_a[1] = 32'h12345678;
      wait_strobe("t3_strobe");
      chk("t3_wr", 64'({memory_write_request, memory_read_request}), 64'b10);
      chk("t3_addr", 64'(memory_addr), 64'h2000);
      chk("t3_wdata", 64'(memory_write_data), 64'h12345678);
      chk("t3_gid", 64'(grant_id), 64'd1);
      wait_rsp("t3_rsp_seen");
      chk("t3_rsp_valid", 64'(rsp_valid), 64'b010);
      chk("t3_rdata", 64'(rsp_rdata), 64'd0);
      chk("t3_err", 64'(rsp_error), 64'd0);
      req_write = '0;
      wait_idle();

      // timeout, memory silent
      mem_auto = 0;
      do_reset();
      req_read = 3'b011;
      wait_strobe("t4_strobe");
      chk("t4_gid0", 64'(grant_id), 64'd0);
      n = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (memory_read_request) n++; else break;
      end
      chk("t4_wait_cycles", 64'(n), 64'd4);
      chk("t4_rsp_valid", 64'(rsp_valid), 64'b001);
      chk("t4_rsp_error", 64'(rsp_error), 64'b001);
      chk("t4_rdata", 64'(rsp_rdata), 64'd0);
      req_read[0] = 0;
      wait_strobe("t4_next_strobe");
      chk("t4_gid1", 64'(grant_id), 64'd1);
      man_resp = 1; man_rdata = 32'h55;
      @(negedge clk);
      man_resp = 0;
      chk("t4_rsp2", 64'({rsp_valid, rsp_error}), 64'b010_000);
      req_read = '0;
      wait_idle();

      // reset in WAIT, then stray response
      do_reset();
      req_read = 3'b010;
      wait_strobe("t5_strobe");
      chk("t5_gid1", 64'(grant_id), 64'd1);
      @(negedge clk);
      reset = 1; req_read = '0;
      @(negedge clk);
      chk("t5_rst_out", 64'({rsp_valid, rsp_error, memory_read_request, memory_write_request, busy, grant_id}), 64'd0);
      chk("t5_rst_addr", 64'(memory_addr), 64'd0);
      reset = 0; man_resp = 1;
      @(negedge clk);
      man_resp = 0;
      chk("t5_stray", 64'({rsp_valid, busy}), 64'd0);
      req_read = 3'b011;
      wait_strobe("t5_strobe2");
      chk("t5_gid0", 64'(grant_id), 64'd0);
      man_resp = 1;
      @(negedge clk);
      man_resp = 0; req_read = '0;
      wait_idle();

      // spurious response in IDLE, then read+write on requester 2
      do_reset();
      man_resp = 1;
      @(negedge clk);
      man_resp = 0;
      @(negedge clk);
      chk("t6_spurious", 64'({rsp_valid, busy}), 64'd0);
      req_read[2] = 1; req_write[2] = 1; addr_a[2] = 32'h3030; wd_a[2] = 32'hA1B2C3D4;
      wait_strobe("t6_strobe");
      chk("t6_type", 64'({memory_write_request, memory_read_request}), 64'b10);
      chk("t6_gid", 64'(grant_id), 64'd2);
      man_resp = 1; man_rdata = 32'hCAFEF00D;
      @(negedge clk);
      man_resp = 0;
      chk("t6_rsp_valid", 64'(rsp_valid), 64'b100);
      chk("t6_rdata", 64'(rsp_rdata), 64'd0);
      req_read = '0; req_write = '0;
      wait_idle();

      // random traffic
      mem_auto = 1; mem_fix = -1;
      repeat (4000) begin
         @(negedge clk);
         rand_step();
      end
      @(negedge clk);
      reset = 0; req_read = '0; req_write = '0;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
